// File: rtl/jtframe_scan2x_sl_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | jtframe_scan2x_sl_if                                                 |
// | Video bus between the core colour mixer and the line doubler.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface jtframe_scan2x_sl_if #(
  parameter int COLORW = 4
);
  logic                  pxl_cen;
  logic                  pxl2_cen;
  logic                  base_hs;
  logic [3*COLORW-1:0]   base_pxl;
  logic [1:0]            sl_mode;
  logic [3*COLORW-1:0]   x2_pxl;
  logic                  x2_hs;

  modport master (
    output pxl_cen, pxl2_cen, base_hs, base_pxl, sl_mode,
    input  x2_pxl, x2_hs
  );

  modport slave (
    input  pxl_cen, pxl2_cen, base_hs, base_pxl, sl_mode,
    output x2_pxl, x2_hs
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_scan2x_sl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | jtframe_scan2x_sl                                                    |
// | 15 kHz to 31 kHz line doubler with optional scanline darkening.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jtframe_scan2x_sl #(
  parameter int COLORW = 4,
  parameter int HLEN   = 512,
  parameter int HS_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  jtframe_scan2x_sl_if.slave vid
);
  localparam int            PW       = 3*COLORW;
  localparam int            AW       = (HLEN > 1) ? $clog2(HLEN) : 1;
  localparam int            LW       = AW + 1;
  localparam logic [AW-1:0] ADDR_MAX = AW'(HLEN-1);
  localparam logic [LW-1:0] HS_CMP   = LW'(HS_LEN);
  localparam logic [LW-1:0] LEN_RST  = LW'(HLEN);

  logic [PW-1:0] mem_q [2][HLEN];

  logic          hs_l_q;
  logic          hs_rise;
  logic [AW-1:0] wraddr_q, wraddr_d, wr_ptr;
  logic          wrbank_q, wrbank_d;
  logic [LW-1:0] linelen_q, linelen_d;
  logic [AW-1:0] rdaddr_q, rdaddr_d;
  logic          half_q, half_d;
  logic [PW-1:0] rd_word;
  logic [PW-1:0] x2_pxl_q, x2_pxl_d;
  logic          x2_hs_q, x2_hs_d;

  function automatic logic [PW-1:0] shade(
    input logic [PW-1:0] pxl,
    input logic [1:0]    mode,
    input logic          dim
  );
    logic [PW-1:0]     res;
    logic [COLORW-1:0] c;
    res = pxl;
    if (dim) begin
      for (int i = 0; i < 3; i++) begin
        c = pxl[i*COLORW +: COLORW];
        case (mode)
          2'd1:    c = c - (c >> 2);
          2'd2:    c = c >> 1;
          2'd3:    c = c >> 2;
          default: c = c;
        endcase
        res[i*COLORW +: COLORW] = c;
      end
    end
    return res;
  endfunction

  assign hs_rise = vid.base_hs & ~hs_l_q;

  // A rising edge with nothing written since the previous edge leaves the
  // line length and bank selection untouched.
  always_comb begin
    wraddr_d  = wraddr_q;
    wrbank_d  = wrbank_q;
    linelen_d = linelen_q;
    if (vid.pxl_cen) begin
      if (hs_rise) begin
        wraddr_d = '0;
        if (wraddr_q != '0) begin
          linelen_d = LW'(wraddr_q);
          wrbank_d  = ~wrbank_q;
        end
      end else if (wraddr_q != ADDR_MAX) begin
        wraddr_d = wraddr_q + AW'(1);
      end
    end
  end

  assign wr_ptr  = hs_rise ? '0 : wraddr_q;
  assign rd_word = mem_q[~wrbank_q][rdaddr_q];

  always_comb begin
    rdaddr_d = rdaddr_q;
    half_d   = half_q;
    x2_pxl_d = x2_pxl_q;
    x2_hs_d  = x2_hs_q;
    if (vid.pxl2_cen) begin
      x2_pxl_d = shade(rd_word, vid.sl_mode, half_q);
      x2_hs_d  = LW'(rdaddr_q) < HS_CMP;
      // Input hsync realigns the replay and takes priority over the wrap
      if (vid.pxl_cen && hs_rise) begin
        rdaddr_d = '0;
        half_d   = 1'b0;
      end else if (LW'(rdaddr_q) == linelen_q - LW'(1)) begin
        rdaddr_d = '0;
        half_d   = ~half_q;
      end else begin
        rdaddr_d = rdaddr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_l_q    <= 1'b0;
      wraddr_q  <= '0;
      wrbank_q  <= 1'b0;
      linelen_q <= LEN_RST;
      rdaddr_q  <= '0;
      half_q    <= 1'b0;
      x2_pxl_q  <= '0;
      x2_hs_q   <= 1'b0;
    end else begin
      if (vid.pxl_cen) hs_l_q <= vid.base_hs;
      wraddr_q  <= wraddr_d;
      wrbank_q  <= wrbank_d;
      linelen_q <= linelen_d;
      rdaddr_q  <= rdaddr_d;
      half_q    <= half_d;
      x2_pxl_q  <= x2_pxl_d;
      x2_hs_q   <= x2_hs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (vid.pxl_cen) mem_q[wrbank_d][wr_ptr] <= vid.base_pxl;
  end

  assign vid.x2_pxl = x2_pxl_q;
  assign vid.x2_hs  = x2_hs_q;
endmodule
`default_nettype wire

// File: tb/tb_jtframe_scan2x_sl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_jtframe_scan2x_sl                                                 |
// | Directed bench for the line doubler: ramp and flat lines.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_jtframe_scan2x_sl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  jtframe_scan2x_sl_if #(.COLORW(4)) vid();

  jtframe_scan2x_sl #(
    .COLORW(4),
    .HLEN  (512),
    .HS_LEN(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vid(vid)
  );

  always #5 clk = ~clk;

  // One pxl2_cen tick spans two clocks; outputs are sampled on the negedge
  // following the enabled posedge.
  task automatic step(input logic pc, input logic hs, input logic [11:0] px);
    @(negedge clk);
    vid.pxl_cen  = pc;
    vid.pxl2_cen = 1'b1;
    vid.base_hs  = hs;
    vid.base_pxl = px;
    @(negedge clk);
    vid.pxl_cen  = 1'b0;
    vid.pxl2_cen = 1'b0;
  endtask

  // Sends one input line of plen pxl_cen ticks (hsync on ticks 0..19) and
  // scores the replay of the previous line, which had len stored pixels.
  task automatic run_line(input int plen, input bit ramp_in, input logic [11:0] cval,
                          input int len, input bit ramp_out,
                          input logic [11:0] e0, input logic [11:0] e1,
                          output int bad_p, output int bad_h,
                          output string info_p, output string info_h);
    logic [11:0] px, exp_p;
    logic        exp_h;
    int          m, a, h;
    bad_p = 0; bad_h = 0; info_p = ""; info_h = "";
    for (int k = 0; k < plen; k++) begin
      for (int s = 0; s < 2; s++) begin
        px = ramp_in ? ((k == 0) ? 12'd0 : 12'(k-1)) : cval;
        step(s == 0, k < 20, px);
        m = 2*k + s;
        if (m >= 1) begin
          a     = (m-1) % len;
          h     = ((m-1) / len) % 2;
          exp_p = ramp_out ? 12'(a) : ((h == 1) ? e1 : e0);
          exp_h = (a < 32);
          if (vid.x2_pxl !== exp_p) begin
            if (bad_p == 0) info_p = $sformatf("first at tick %0d got %h want %h", m, vid.x2_pxl, exp_p);
            bad_p++;
          end
          if (vid.x2_hs !== exp_h) begin
            if (bad_h == 0) info_h = $sformatf("first at tick %0d got %b want %b", m, vid.x2_hs, exp_h);
            bad_h++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (vid.x2_pxl !== 12'h000) begin
      errors++; $display("FAIL reset_pxl got %h want 000", vid.x2_pxl);
    end
    checks++;
    if (vid.x2_hs !== 1'b0) begin
      errors++; $display("FAIL reset_hs got %b want 0", vid.x2_hs);
    end
    rst = 1'b0;
  endtask

  task automatic test_doubling();
    int bp, bh; string ip, ih;
    vid.sl_mode = 2'd0;
    run_line(401, 1, 12'h0, 400, 1, 12'h0, 12'h0, bp, bh, ip, ih);
    for (int l = 2; l <= 3; l++) begin
      run_line(401, 1, 12'h0, 400, 1, 12'h0, 12'h0, bp, bh, ip, ih);
      checks++;
      if (bp !== 0) begin errors++; $display("FAIL doubling_l%0d_pxl bad=%0d want 0, %s", l, bp, ip); end
      checks++;
      if (bh !== 0) begin errors++; $display("FAIL doubling_l%0d_hs bad=%0d want 0, %s", l, bh, ih); end
    end
  endtask

  task automatic test_shade();
    int bp, bh; string ip, ih;
    logic [1:0]  modes [3] = '{2'd2, 2'd1, 2'd3};
    logic [11:0] dims  [3] = '{12'h777, 12'hCCC, 12'h333};
    vid.sl_mode = 2'd2;
    run_line(401, 0, 12'hFFF, 400, 1, 12'h0, 12'h0, bp, bh, ip, ih);
    for (int i = 0; i < 3; i++) begin
      vid.sl_mode = modes[i];
      run_line(401, 0, 12'hFFF, 400, 0, 12'hFFF, dims[i], bp, bh, ip, ih);
      checks++;
      if (bp !== 0) begin errors++; $display("FAIL shade_mode%0d_pxl bad=%0d want 0, %s", modes[i], bp, ip); end
      checks++;
      if (bh !== 0) begin errors++; $display("FAIL shade_mode%0d_hs bad=%0d want 0, %s", modes[i], bh, ih); end
    end
  endtask

  task automatic test_line_length();
    int bp, bh; string ip, ih;
    int plens [4] = '{401, 257, 401, 401};
    int lens  [4] = '{400, 400, 256, 400};
    bit rmp   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vid.sl_mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      run_line(plens[i], 1, 12'h0, lens[i], rmp[i], 12'hFFF, 12'hFFF, bp, bh, ip, ih);
      checks++;
      if (bp !== 0) begin errors++; $display("FAIL linelen_%0d_pxl bad=%0d want 0, %s", i, bp, ip); end
      checks++;
      if (bh !== 0) begin errors++; $display("FAIL linelen_%0d_hs bad=%0d want 0, %s", i, bh, ih); end
    end
  endtask

  task automatic test_long_line();
    int bp, bh; string ip, ih;
    int plens [3] = '{601, 401, 401};
    int lens  [3] = '{400, 511, 400};
    for (int i = 0; i < 3; i++) begin
      run_line(plens[i], 1, 12'h0, lens[i], 1, 12'h0, 12'h0, bp, bh, ip, ih);
      checks++;
      if (bp !== 0) begin errors++; $display("FAIL long_%0d_pxl bad=%0d want 0, %s", i, bp, ip); end
      checks++;
      if (bh !== 0) begin errors++; $display("FAIL long_%0d_hs bad=%0d want 0, %s", i, bh, ih); end
    end
  endtask

  task automatic test_early_hs();
    int bp, bh; string ip, ih;
    int plens [3] = '{391, 401, 401};
    int lens  [3] = '{400, 390, 400};
    for (int i = 0; i < 3; i++) begin
      run_line(plens[i], 1, 12'h0, lens[i], 1, 12'h0, 12'h0, bp, bh, ip, ih);
      checks++;
      if (bp !== 0) begin errors++; $display("FAIL early_%0d_pxl bad=%0d want 0, %s", i, bp, ip); end
      checks++;
      if (bh !== 0) begin errors++; $display("FAIL early_%0d_hs bad=%0d want 0, %s", i, bh, ih); end
    end
  endtask

  task automatic test_rst_midline();
    int bp, bh; string ip, ih;
    run_line(100, 1, 12'h0, 400, 1, 12'h0, 12'h0, bp, bh, ip, ih);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (vid.x2_pxl !== 12'h000) begin
      errors++; $display("FAIL rst_mid_pxl got %h want 000", vid.x2_pxl);
    end
    checks++;
    if (vid.x2_hs !== 1'b0) begin
      errors++; $display("FAIL rst_mid_hs got %b want 0", vid.x2_hs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_line(401, 1, 12'h0, 400, 1, 12'h0, 12'h0, bp, bh, ip, ih);
    for (int l = 2; l <= 3; l++) begin
      run_line(401, 1, 12'h0, 400, 1, 12'h0, 12'h0, bp, bh, ip, ih);
      checks++;
      if (bp !== 0) begin errors++; $display("FAIL rst_resume_l%0d_pxl bad=%0d want 0, %s", l, bp, ip); end
      checks++;
      if (bh !== 0) begin errors++; $display("FAIL rst_resume_l%0d_hs bad=%0d want 0, %s", l, bh, ih); end
    end
  endtask

  initial begin
    vid.pxl_cen  = 1'b0;
    vid.pxl2_cen = 1'b0;
    vid.base_hs  = 1'b0;
    vid.base_pxl = 12'h000;
    vid.sl_mode  = 2'd0;
    test_reset();
    test_doubling();
    test_shade();
    test_line_length();
    test_long_line();
    test_early_hs();
    test_rst_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
